// File: rtl/sha256_ctrl_pkg.sv
// sha256_ctrl_pkg: state encodings and sizing constants shared by the SHA-256 sequencer
package sha256_ctrl_pkg;
  localparam int ROUNDS    = 64;
  localparam int DIG_WORDS = 8;
  localparam int CNT_EOC   = 64;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;
endpackage

// File: rtl/sha256_ctrl_chk.sv
// sha256_ctrl_chk: shadow round/address counter that flags any divergence from the real counter
module sha256_ctrl_chk
  import sha256_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       chk_i,
  input  logic       soc_n_i,
  input  logic       rd_i,
  input  logic [5:0] cnt_addr_i,
  input  logic       cnt_eoc_i,
  output logic       mism_o,
  output logic       err_o
);
  logic [6:0] shadow_q, shadow_d;
  logic       err_q, err_d;
  // shadow tracks clear / round stepping up to eoc / low-bit readout stepping
  always_comb begin
    shadow_d = !soc_n_i ? 7'd0 :
               (run_i && shadow_q < 7'(CNT_EOC)) ? shadow_q + 7'd1 :
               rd_i ? {shadow_q[6:3], shadow_q[2:0] + 3'd1} : shadow_q;
    mism_o   = chk_i && ({cnt_eoc_i, cnt_addr_i} != shadow_q);
    err_d    = err_q | mism_o;
  end
  // shadow counter and sticky error register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= 7'd0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end
  assign err_o = err_q;
endmodule

// File: rtl/sha256_ctrl.sv
// sha256_ctrl: SHA-256 block/round/digest sequencer; SHA256_CTRL_CHECK_EN adds a shadow-counter checker
module sha256_ctrl
  import sha256_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blk_valid,
  input  logic       blk_last,
  output logic       blk_ready,
  input  logic       dig_ready,
  output logic       dig_valid,
  output logic [2:0] dig_idx,
  input  logic [5:0] cnt_addr,
  input  logic       cnt_eoc,
  output logic       core_soc_n,
  output logic       core_rd,
  output logic       core_load,
  output logic       core_init,
  output logic       core_acc,
  output logic       busy,
  output logic       err
);
  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   accept, mism;

  if (ROUNDS != CNT_EOC) begin : g_rounds_bad
    $error("ROUNDS must match the counter eoc point");
  end

  assign accept = blk_valid && blk_ready;

`ifdef SHA256_CTRL_CHECK_EN
  sha256_ctrl_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (state_q == ST_RUN),
    .chk_i      (state_q == ST_RUN || state_q == ST_OUT),
    .soc_n_i    (core_soc_n),
    .rd_i       (core_rd),
    .cnt_addr_i (cnt_addr),
    .cnt_eoc_i  (cnt_eoc),
    .mism_o     (mism),
    .err_o      (err)
  );
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt_addr[5:3];
  assign mism = 1'b0;
  assign err  = 1'b0;
`endif

  // state and last-block flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // next-state: accept -> rounds -> chain or read out -> idle
  always_comb begin
    state_d = ST_IDLE;
    last_d  = accept ? blk_last : last_q;
    case (state_q)
      ST_IDLE: state_d = accept ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = mism ? ST_ERR : !cnt_eoc ? ST_RUN : last_q ? ST_OUT : ST_WAIT;
      ST_WAIT: state_d = accept ? ST_RUN : ST_WAIT;
      ST_OUT:  state_d = mism ? ST_ERR :
                         (dig_ready && dig_idx == 3'(DIG_WORDS - 1)) ? ST_IDLE : ST_OUT;
`ifdef SHA256_CTRL_CHECK_EN
      ST_ERR:  state_d = ST_ERR;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs from state, with load/init/acc/rd qualified combinationally
  always_comb begin
    blk_ready  = state_q == ST_IDLE || state_q == ST_WAIT;
    core_soc_n = state_q == ST_RUN || state_q == ST_OUT;
    dig_valid  = state_q == ST_OUT;
    dig_idx    = dig_valid ? cnt_addr[2:0] : 3'd0;
    core_rd    = dig_valid && dig_ready;
    core_load  = accept;
    core_init  = accept && state_q == ST_IDLE;
    core_acc   = state_q == ST_RUN && cnt_eoc;
    busy       = state_q != ST_IDLE;
  end
endmodule

// File: tb/tb_sha256_ctrl.sv
// tb_sha256_ctrl: directed bench for sha256_ctrl with a behavioural round/address counter
module tb_sha256_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       blk_valid = 1'b0, blk_last = 1'b0, dig_ready = 1'b0;
  logic       blk_ready, dig_valid, core_soc_n, core_rd, core_load, core_init, core_acc, busy, err;
  logic [2:0] dig_idx;
  logic [5:0] cnt_addr;
  logic       cnt_eoc;
  logic [6:0] c = 7'd0;
  logic       force_en = 1'b0;
  logic [5:0] force_val = 6'd0;
  int         pass = 0, total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!core_soc_n) c <= 7'd0;
    else if (!c[6]) c <= c + 7'd1;
    else if (core_rd) c[2:0] <= c[2:0] + 3'd1;
  end
  assign cnt_addr = force_en ? force_val : c[5:0];
  assign cnt_eoc  = c[6];

  sha256_ctrl dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready),
    .dig_ready(dig_ready), .dig_valid(dig_valid), .dig_idx(dig_idx), .cnt_addr(cnt_addr),
    .cnt_eoc(cnt_eoc), .core_soc_n(core_soc_n), .core_rd(core_rd), .core_load(core_load),
    .core_init(core_init), .core_acc(core_acc), .busy(busy), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    #1;
    total++;
    if ({blk_ready, busy, core_soc_n, dig_valid, core_acc, core_load, core_rd, err} !== 8'b1000_0000)
      $display("FAIL reset_outputs: got %b want 10000000",
               {blk_ready, busy, core_soc_n, dig_valid, core_acc, core_load, core_rd, err});
    else pass++;
  endtask

  task automatic test_single(input string tag);
    bit bad = 0;
    tick;
    blk_valid = 1'b1; blk_last = 1'b1;
    #1;
    total++;
    if ({core_load, core_init} !== 2'b11) $display("FAIL %s_accept: load/init got %b want 11", tag, {core_load, core_init});
    else pass++;
    for (int k = 1; k <= 65; k++) begin
      tick;
      blk_valid = 1'b0; blk_last = 1'b0;
      #1;
      if (k < 65 && (core_acc !== 1'b0 || blk_ready !== 1'b0 || core_soc_n !== 1'b1)) bad = 1;
    end
    total++;
    if (core_acc !== 1'b1) $display("FAIL %s_acc_t65: got %b want 1", tag, core_acc);
    else pass++;
    total++;
    if (bad) $display("FAIL %s_run_phase: got acc/ready/soc_n wrong before T+65 want acc=0 ready=0 soc_n=1", tag);
    else pass++;
    tick;
    total++;
    if (dig_valid !== 1'b1 || dig_idx !== 3'd0) $display("FAIL %s_dig_t66: got valid=%b idx=%0d want 1 0", tag, dig_valid, dig_idx);
    else pass++;
    for (int i = 0; i < 8; i++) begin
      dig_ready = 1'b1;
      #1;
      total++;
      if (dig_valid !== 1'b1 || dig_idx !== 3'(i) || core_rd !== 1'b1)
        $display("FAIL %s_word%0d: got valid=%b idx=%0d rd=%b want 1 %0d 1", tag, i, dig_valid, dig_idx, core_rd, i);
      else pass++;
      tick;
    end
    dig_ready = 1'b0;
    #1;
    total++;
    if ({busy, core_soc_n, blk_ready, dig_valid} !== 4'b0010)
      $display("FAIL %s_idle_t74: got busy/soc_n/ready/valid=%b want 0010", tag, {busy, core_soc_n, blk_ready, dig_valid});
    else pass++;
  endtask

  task automatic test_back_to_back;
    bit bad = 0;
    bit pat [10] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int exp_idx = 0;
    tick;
    blk_valid = 1'b1; blk_last = 1'b0;
    #1;
    total++;
    if ({core_load, core_init} !== 2'b11) $display("FAIL b2b_accept1: load/init got %b want 11", {core_load, core_init});
    else pass++;
    for (int k = 1; k <= 65; k++) begin
      tick;
      blk_last = 1'b1;
      #1;
      if (k < 65 && (blk_ready !== 1'b0 || core_load !== 1'b0 || core_acc !== 1'b0)) bad = 1;
    end
    total++;
    if (bad) $display("FAIL b2b_held_in_run: got ready/load/acc asserted want 0");
    else pass++;
    total++;
    if (core_acc !== 1'b1) $display("FAIL b2b_acc1: got %b want 1", core_acc);
    else pass++;
    tick;
    total++;
    if ({core_load, core_init, blk_ready} !== 3'b101)
      $display("FAIL b2b_accept2_t66: load/init/ready got %b want 101", {core_load, core_init, blk_ready});
    else pass++;
    bad = 0;
    for (int k = 67; k <= 131; k++) begin
      tick;
      blk_valid = 1'b0; blk_last = 1'b0;
      #1;
      if (k < 131 && (core_acc !== 1'b0 || dig_valid !== 1'b0)) bad = 1;
    end
    total++;
    if (core_acc !== 1'b1 || bad) $display("FAIL b2b_acc2_t131: got acc=%b early=%0d want 1 0", core_acc, bad);
    else pass++;
    tick;
    for (int j = 0; j < 10; j++) begin
      dig_ready = pat[j];
      #1;
      total++;
      if (dig_valid !== 1'b1 || dig_idx !== 3'(exp_idx) || core_rd !== pat[j])
        $display("FAIL stall_cyc%0d: got valid=%b idx=%0d rd=%b want 1 %0d %b", j, dig_valid, dig_idx, core_rd, exp_idx, pat[j]);
      else pass++;
      if (pat[j]) exp_idx++;
      tick;
    end
    dig_ready = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || dig_valid !== 1'b0) $display("FAIL stall_done: got busy=%b valid=%b want 0 0", busy, dig_valid);
    else pass++;
  endtask

  task automatic test_reset_mid_run;
    bit bad = 0;
    tick;
    blk_valid = 1'b1; blk_last = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick;
      blk_valid = 1'b0; blk_last = 1'b0;
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
    total++;
    if ({blk_ready, busy, core_soc_n, core_acc} !== 4'b1000)
      $display("FAIL midrun_reset: ready/busy/soc_n/acc got %b want 1000", {blk_ready, busy, core_soc_n, core_acc});
    else pass++;
    for (int k = 0; k < 60; k++) begin
      tick;
      if (core_acc !== 1'b0 || dig_valid !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    total++;
    if (bad) $display("FAIL midrun_quiet: got acc/valid/busy after abort want all 0");
    else pass++;
  endtask

`ifdef SHA256_CTRL_CHECK_EN
  task automatic test_check;
    bit bad = 0;
    tick;
    blk_valid = 1'b1; blk_last = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      blk_valid = 1'b0; blk_last = 1'b0;
    end
    force_en = 1'b1; force_val = 6'd5;
    #1;
    total++;
    if (err !== 1'b0) $display("FAIL chk_before: err got %b want 0", err);
    else pass++;
    tick;
    force_en = 1'b0;
    #1;
    total++;
    if ({err, busy, core_soc_n, blk_ready, dig_valid} !== 5'b11000)
      $display("FAIL chk_err: err/busy/soc_n/ready/valid got %b want 11000", {err, busy, core_soc_n, blk_ready, dig_valid});
    else pass++;
    for (int k = 0; k < 80; k++) begin
      tick;
      if (err !== 1'b1 || busy !== 1'b1 || core_acc !== 1'b0 || dig_valid !== 1'b0) bad = 1;
    end
    total++;
    if (bad) $display("FAIL chk_sticky: got err/busy dropped or acc/valid seen want stuck in error");
    else pass++;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
    total++;
    if (err !== 1'b0 || busy !== 1'b0) $display("FAIL chk_reset: got err=%b busy=%b want 0 0", err, busy);
    else pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single("single");
    test_back_to_back;
    test_reset_mid_run;
    test_single("after_reset");
`ifdef SHA256_CTRL_CHECK_EN
    test_check;
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
